// File: rtl/combat_resolver.sv
// combat_resolver: per-frame two-player hit resolver.
// Each player instance resolves the opponent's attack against its own
// hurtbox, then tracks HP, stun, knockback, KO and the connect latch for
// the incoming attack. Everything advances only on SCEN frames.
module combat_resolver #(
  parameter int POS_WIDTH = 10,
  parameter int HP_MAX    = 100,
  parameter int HP_W      = 8,
  parameter int HURT_W    = 16,
  parameter int HURT_H    = 28,
  parameter int HURT_OFFX = -8,
  parameter int HURT_OFFY = -28,
  parameter int L_W       = 20,
  parameter int L_H       = 12,
  parameter int L_FWD     = 16,
  parameter int L_UP      = -16,
  parameter int H_W       = 28,
  parameter int H_H       = 14,
  parameter int H_FWD     = 16,
  parameter int H_UP      = -18,
  parameter int L_DMG     = 5,
  parameter int H_DMG     = 12,
  parameter int CHIP_DMG  = 1,
  parameter int L_STUN    = 8,
  parameter int H_STUN    = 16,
  parameter int BLK_STUN  = 4,
  parameter int L_KB_X    = 2,
  parameter int H_KB_X    = 6,
  parameter int KB_Y      = -2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCEN,
  input  logic                 round_start,
  input  logic [POS_WIDTH-1:0] p1_x,
  input  logic [POS_WIDTH-1:0] p1_y,
  input  logic                 p1_face_right,
  input  logic                 p1_atk_active,
  input  logic                 p1_atk_heavy,
  input  logic                 p1_block,
  input  logic [POS_WIDTH-1:0] p2_x,
  input  logic [POS_WIDTH-1:0] p2_y,
  input  logic                 p2_face_right,
  input  logic                 p2_atk_active,
  input  logic                 p2_atk_heavy,
  input  logic                 p2_block,
  output logic                 p1_hit_event,
  output logic                 p1_block_event,
  output logic                 p1_stun_active,
  output logic signed [7:0]    p1_kb_dx,
  output logic signed [7:0]    p1_kb_dy,
  output logic [HP_W-1:0]      p1_hp,
  output logic                 p1_ko,
  output logic                 p2_hit_event,
  output logic                 p2_block_event,
  output logic                 p2_stun_active,
  output logic signed [7:0]    p2_kb_dx,
  output logic signed [7:0]    p2_kb_dy,
  output logic [HP_W-1:0]      p2_hp,
  output logic                 p2_ko,
  output logic                 round_over
);

  localparam int GW     = POS_WIDTH + 2;
  localparam int STUN_W = 8;

  // Attacker hitbox (class-dependent, mirrored by facing) vs defender
  // hurtbox; strict compares so edge-touching boxes do not overlap.
  function automatic logic boxes_overlap(
    input logic [POS_WIDTH-1:0] ax,
    input logic [POS_WIDTH-1:0] ay,
    input logic                 a_face,
    input logic                 a_heavy,
    input logic [POS_WIDTH-1:0] dx,
    input logic [POS_WIDTH-1:0] dy
  );
    logic signed [GW-1:0] s_ax, s_ay, s_dx, s_dy;
    logic signed [GW-1:0] fwd, bw, bh, up;
    logic signed [GW-1:0] bx0, by0, hx0, hy0;
    s_ax = $signed({2'b00, ax});
    s_ay = $signed({2'b00, ay});
    s_dx = $signed({2'b00, dx});
    s_dy = $signed({2'b00, dy});
    fwd  = a_heavy ? GW'(H_FWD) : GW'(L_FWD);
    bw   = a_heavy ? GW'(H_W)   : GW'(L_W);
    bh   = a_heavy ? GW'(H_H)   : GW'(L_H);
    up   = a_heavy ? GW'(H_UP)  : GW'(L_UP);
    bx0  = a_face ? (s_ax + fwd) : (s_ax - (fwd + bw));
    by0  = s_ay + up;
    hx0  = s_dx + GW'(HURT_OFFX);
    hy0  = s_dy + GW'(HURT_OFFY);
    return (bx0 < hx0 + GW'(HURT_W)) && (hx0 < bx0 + bw) &&
           (by0 < hy0 + GW'(HURT_H)) && (hy0 < by0 + bh);
  endfunction

  logic [2*POS_WIDTH-1:0] w_x_v;
  logic [2*POS_WIDTH-1:0] w_y_v;
  logic [1:0]             w_face_v;
  logic [1:0]             w_atk_v;
  logic [1:0]             w_heavy_v;
  logic [1:0]             w_block_v;
  logic [1:0]             w_ko_nxt_v;
  logic [1:0]             w_hit_v;
  logic [1:0]             w_blk_v;
  logic [1:0]             w_stun_v;
  logic [1:0]             w_ko_v;
  logic [2*HP_W-1:0]      w_hp_v;
  logic [15:0]            w_kb_dx_v;
  logic [15:0]            w_kb_dy_v;
  logic                   r_round_over;

  assign w_x_v     = {p2_x, p1_x};
  assign w_y_v     = {p2_y, p1_y};
  assign w_face_v  = {p2_face_right, p1_face_right};
  assign w_atk_v   = {p2_atk_active, p1_atk_active};
  assign w_heavy_v = {p2_atk_heavy, p1_atk_heavy};
  assign w_block_v = {p2_block, p1_block};

  // g is the defender, A the attacker whose hits land on g.
  for (genvar g = 0; g < 2; g++) begin : g_player
    localparam int A = 1 - g;

    logic [POS_WIDTH-1:0] w_ax, w_ay, w_dx, w_dy;
    logic                 w_land, w_guard, w_clean, w_ko_nxt;
    logic [HP_W-1:0]      w_dmg, w_hp_nxt;
    logic [STUN_W-1:0]    w_stun_nxt;
    logic signed [7:0]    w_kb_mag, w_kb_dx_nxt, w_kb_dy_nxt;
    logic                 r_conn, r_hit, r_blk, r_stun_act, r_ko;
    logic [HP_W-1:0]      r_hp;
    logic [STUN_W-1:0]    r_stun;
    logic signed [7:0]    r_kb_dx, r_kb_dy;

    assign w_ax = w_x_v[A*POS_WIDTH +: POS_WIDTH];
    assign w_ay = w_y_v[A*POS_WIDTH +: POS_WIDTH];
    assign w_dx = w_x_v[g*POS_WIDTH +: POS_WIDTH];
    assign w_dy = w_y_v[g*POS_WIDTH +: POS_WIDTH];

    // Decide whether the opponent's attack lands here and what it does.
    always_comb begin
      w_land  = w_atk_v[A] && !r_conn && !r_round_over &&
                boxes_overlap(w_ax, w_ay, w_face_v[A], w_heavy_v[A], w_dx, w_dy);
      // Equal x counts as facing the attacker.
      w_guard = w_block_v[g] && (r_stun == {STUN_W{1'b0}}) &&
                ((w_ax == w_dx) || (w_face_v[g] == (w_ax > w_dx)));
      w_clean = w_land && !w_guard;
      w_dmg   = w_guard ? HP_W'(CHIP_DMG) :
                (w_heavy_v[A] ? HP_W'(H_DMG) : HP_W'(L_DMG));
      w_kb_mag = w_heavy_v[A] ? (w_guard ? 8'(H_KB_X >>> 1) : 8'(H_KB_X))
                              : (w_guard ? 8'(L_KB_X >>> 1) : 8'(L_KB_X));
      if (w_land) begin
        w_hp_nxt    = (r_hp > w_dmg) ? (r_hp - w_dmg) : {HP_W{1'b0}};
        w_stun_nxt  = w_guard ? STUN_W'(BLK_STUN) :
                      (w_heavy_v[A] ? STUN_W'(H_STUN) : STUN_W'(L_STUN));
        w_kb_dx_nxt = w_face_v[A] ? w_kb_mag : -w_kb_mag;
        w_kb_dy_nxt = w_guard ? 8'sd0 : 8'(KB_Y);
      end else begin
        w_hp_nxt    = r_hp;
        w_stun_nxt  = (r_stun != {STUN_W{1'b0}}) ? (r_stun - STUN_W'(1)) : {STUN_W{1'b0}};
        w_kb_dx_nxt = r_kb_dx;
        w_kb_dy_nxt = r_kb_dy;
      end
      w_ko_nxt = r_ko || (w_hp_nxt == {HP_W{1'b0}});
    end

    // Per-frame state update; round restart overrides any hit this frame.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_hp       <= HP_W'(HP_MAX);
        r_stun     <= {STUN_W{1'b0}};
        r_stun_act <= 1'b0;
        r_hit      <= 1'b0;
        r_blk      <= 1'b0;
        r_ko       <= 1'b0;
        r_conn     <= 1'b0;
        r_kb_dx    <= 8'sd0;
        r_kb_dy    <= 8'sd0;
      end else if (SCEN) begin
        if (round_start) begin
          r_hp       <= HP_W'(HP_MAX);
          r_stun     <= {STUN_W{1'b0}};
          r_stun_act <= 1'b0;
          r_hit      <= 1'b0;
          r_blk      <= 1'b0;
          r_ko       <= 1'b0;
          r_conn     <= 1'b0;
          r_kb_dx    <= 8'sd0;
          r_kb_dy    <= 8'sd0;
        end else begin
          r_hp       <= w_hp_nxt;
          r_stun     <= w_stun_nxt;
          r_stun_act <= (w_stun_nxt != {STUN_W{1'b0}});
          r_hit      <= w_clean;
          r_blk      <= w_land && w_guard;
          r_ko       <= w_ko_nxt;
          r_conn     <= w_atk_v[A] && (r_conn || w_land);
          r_kb_dx    <= w_kb_dx_nxt;
          r_kb_dy    <= w_kb_dy_nxt;
        end
      end
    end

    assign w_ko_nxt_v[g]             = w_ko_nxt;
    assign w_hit_v[g]                = r_hit;
    assign w_blk_v[g]                = r_blk;
    assign w_stun_v[g]               = r_stun_act;
    assign w_ko_v[g]                 = r_ko;
    assign w_hp_v[g*HP_W +: HP_W]    = r_hp;
    assign w_kb_dx_v[g*8 +: 8]       = r_kb_dx;
    assign w_kb_dy_v[g*8 +: 8]       = r_kb_dy;
  end

  // Round-over flag follows the KO flags and blocks further resolution.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_round_over <= 1'b0;
    end else if (SCEN) begin
      r_round_over <= round_start ? 1'b0 : (w_ko_nxt_v != 2'b00);
    end
  end

  assign p1_hit_event   = w_hit_v[0];
  assign p1_block_event = w_blk_v[0];
  assign p1_stun_active = w_stun_v[0];
  assign p1_ko          = w_ko_v[0];
  assign p1_hp          = w_hp_v[HP_W-1:0];
  assign p1_kb_dx       = w_kb_dx_v[7:0];
  assign p1_kb_dy       = w_kb_dy_v[7:0];
  assign p2_hit_event   = w_hit_v[1];
  assign p2_block_event = w_blk_v[1];
  assign p2_stun_active = w_stun_v[1];
  assign p2_ko          = w_ko_v[1];
  assign p2_hp          = w_hp_v[2*HP_W-1:HP_W];
  assign p2_kb_dx       = w_kb_dx_v[15:8];
  assign p2_kb_dy       = w_kb_dy_v[15:8];
  assign round_over     = r_round_over;

endmodule

// File: tb/tb_combat_resolver.sv
// Bench for combat_resolver: directed scenarios plus a randomized run
// against an integer-arithmetic model of the resolver rules.
module tb_combat_resolver;
  logic clk, reset, SCEN, round_start;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic p1_face_right, p1_atk_active, p1_atk_heavy, p1_block;
  logic p2_face_right, p2_atk_active, p2_atk_heavy, p2_block;
  logic p1_hit_event, p1_block_event, p1_stun_active, p1_ko;
  logic p2_hit_event, p2_block_event, p2_stun_active, p2_ko;
  logic signed [7:0] p1_kb_dx, p1_kb_dy, p2_kb_dx, p2_kb_dy;
  logic [7:0] p1_hp, p2_hp;
  logic round_over;

  int n_pass, n_total;
  int m_hp[2], m_stun[2], m_kbx[2], m_kby[2];
  bit m_conn[2], m_ko[2], m_hit[2], m_blk[2];

  combat_resolver dut (
    .clk(clk), .reset(reset), .SCEN(SCEN), .round_start(round_start),
    .p1_x(p1_x), .p1_y(p1_y), .p1_face_right(p1_face_right),
    .p1_atk_active(p1_atk_active), .p1_atk_heavy(p1_atk_heavy), .p1_block(p1_block),
    .p2_x(p2_x), .p2_y(p2_y), .p2_face_right(p2_face_right),
    .p2_atk_active(p2_atk_active), .p2_atk_heavy(p2_atk_heavy), .p2_block(p2_block),
    .p1_hit_event(p1_hit_event), .p1_block_event(p1_block_event),
    .p1_stun_active(p1_stun_active), .p1_kb_dx(p1_kb_dx), .p1_kb_dy(p1_kb_dy),
    .p1_hp(p1_hp), .p1_ko(p1_ko),
    .p2_hit_event(p2_hit_event), .p2_block_event(p2_block_event),
    .p2_stun_active(p2_stun_active), .p2_kb_dx(p2_kb_dx), .p2_kb_dy(p2_kb_dy),
    .p2_hp(p2_hp), .p2_ko(p2_ko),
    .round_over(round_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic frame();
    SCEN = 1'b1;
    @(posedge clk); #1;
    SCEN = 1'b0;
  endtask

  task automatic restart_round();
    p1_atk_active = 1'b0; p2_atk_active = 1'b0;
    round_start = 1'b1;
    frame();
    round_start = 1'b0;
  endtask

  // Rectangle test from the box definitions, plain integer math.
  function automatic bit hits(input int ax, input int ay, input bit af, input bit ah,
                              input int dx, input int dy);
    int w, h, up, bx, by, hx, hy;
    w  = ah ? 28 : 20;
    h  = ah ? 14 : 12;
    up = ah ? -18 : -16;
    bx = af ? ax + 16 : ax - (16 + w);
    by = ay + up;
    hx = dx - 8;
    hy = dy - 28;
    return (bx < hx + 16) && (hx < bx + w) && (by < hy + 28) && (hy < by + h);
  endfunction

  task automatic model_step();
    int x[2], y[2];
    bit fr[2], act[2], hv[2], bl[2], land[2], grd[2];
    bit over;
    x[0] = int'(p1_x); y[0] = int'(p1_y); x[1] = int'(p2_x); y[1] = int'(p2_y);
    fr[0] = p1_face_right; act[0] = p1_atk_active; hv[0] = p1_atk_heavy; bl[0] = p1_block;
    fr[1] = p2_face_right; act[1] = p2_atk_active; hv[1] = p2_atk_heavy; bl[1] = p2_block;
    if (round_start) begin
      for (int i = 0; i < 2; i++) begin
        m_hp[i] = 100; m_stun[i] = 0; m_kbx[i] = 0; m_kby[i] = 0;
        m_conn[i] = 0; m_ko[i] = 0; m_hit[i] = 0; m_blk[i] = 0;
      end
      return;
    end
    over = m_ko[0] || m_ko[1];
    for (int d = 0; d < 2; d++) begin
      int a;
      a = 1 - d;
      land[d] = act[a] && !m_conn[a] && !over && hits(x[a], y[a], fr[a], hv[a], x[d], y[d]);
      grd[d]  = bl[d] && (m_stun[d] == 0) && ((x[a] == x[d]) || (fr[d] == (x[a] > x[d])));
    end
    for (int d = 0; d < 2; d++) begin
      int a, dmg, kb;
      a = 1 - d;
      m_hit[d] = land[d] && !grd[d];
      m_blk[d] = land[d] && grd[d];
      if (land[d]) begin
        dmg = grd[d] ? 1 : (hv[a] ? 12 : 5);
        m_hp[d] = (m_hp[d] > dmg) ? m_hp[d] - dmg : 0;
        m_stun[d] = grd[d] ? 4 : (hv[a] ? 16 : 8);
        kb = hv[a] ? 6 : 2;
        if (grd[d]) kb = kb / 2;
        m_kbx[d] = fr[a] ? kb : -kb;
        m_kby[d] = grd[d] ? 0 : -2;
        if (m_hp[d] == 0) m_ko[d] = 1;
      end else if (m_stun[d] > 0) begin
        m_stun[d] = m_stun[d] - 1;
      end
      m_conn[a] = act[a] && (m_conn[a] || land[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_total++;
    if ({p1_hp, p2_hp} !== {8'd100, 8'd100})
      $display("FAIL reset_hp: got %0d/%0d want 100/100", p1_hp, p2_hp);
    else n_pass++;
    n_total++;
    if ({p1_hit_event, p1_block_event, p1_stun_active, p1_ko,
         p2_hit_event, p2_block_event, p2_stun_active, p2_ko, round_over} !== 9'b0)
      $display("FAIL reset_flags: got nonzero flags, want all 0");
    else n_pass++;
    n_total++;
    if ({p1_kb_dx, p1_kb_dy, p2_kb_dx, p2_kb_dy} !== 32'h0)
      $display("FAIL reset_kb: got %h want 0", {p1_kb_dx, p1_kb_dy, p2_kb_dx, p2_kb_dy});
    else n_pass++;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_total++;
    if (p2_hp !== 8'd100)
      $display("FAIL reset_idle_hp: got %0d want 100", p2_hp);
    else n_pass++;
  endtask

  task automatic test_light_hit();
    int stun_frames;
    p1_x = 10'd100; p1_y = 10'd200; p1_face_right = 1'b1;
    p2_x = 10'd125; p2_y = 10'd200; p2_face_right = 1'b0;
    p1_atk_heavy = 1'b0; p1_atk_active = 1'b1;
    frame();
    n_total++;
    if ({p2_hit_event, p2_block_event, p1_hit_event} !== 3'b100)
      $display("FAIL light_event: got %b want 100", {p2_hit_event, p2_block_event, p1_hit_event});
    else n_pass++;
    n_total++;
    if (p2_hp !== 8'd95) $display("FAIL light_hp: got %0d want 95", p2_hp);
    else n_pass++;
    n_total++;
    if (p2_kb_dx !== 8'sd2 || p2_kb_dy !== -8'sd2)
      $display("FAIL light_kb: got (%0d,%0d) want (2,-2)", p2_kb_dx, p2_kb_dy);
    else n_pass++;
    stun_frames = p2_stun_active ? 1 : 0;
    @(posedge clk); #1;
    n_total++;
    if (p2_hit_event !== 1'b1) $display("FAIL light_hold_noscen: got %b want 1", p2_hit_event);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      frame();
      if (p2_stun_active) stun_frames++;
      n_total++;
      if (p2_hit_event !== 1'b0) $display("FAIL light_rehit: got %b want 0", p2_hit_event);
      else n_pass++;
    end
    p1_atk_active = 1'b0;
    for (int i = 0; i < 9; i++) begin
      frame();
      if (p2_stun_active) stun_frames++;
    end
    n_total++;
    if (stun_frames != 8) $display("FAIL light_stun_len: got %0d want 8", stun_frames);
    else n_pass++;
    n_total++;
    if (p2_hp !== 8'd95 || p2_kb_dx !== 8'sd2 || p2_kb_dy !== -8'sd2)
      $display("FAIL light_after: got hp %0d kb (%0d,%0d) want 95 (2,-2)", p2_hp, p2_kb_dx, p2_kb_dy);
    else n_pass++;
  endtask

  task automatic test_block();
    int stun_frames;
    restart_round();
    p2_block = 1'b1; p2_face_right = 1'b0;
    p1_atk_heavy = 1'b1; p1_atk_active = 1'b1;
    frame();
    n_total++;
    if ({p2_block_event, p2_hit_event} !== 2'b10)
      $display("FAIL block_event: got %b want 10", {p2_block_event, p2_hit_event});
    else n_pass++;
    n_total++;
    if (p2_hp !== 8'd99) $display("FAIL block_hp: got %0d want 99", p2_hp);
    else n_pass++;
    n_total++;
    if (p2_kb_dx !== 8'sd3 || p2_kb_dy !== 8'sd0)
      $display("FAIL block_kb: got (%0d,%0d) want (3,0)", p2_kb_dx, p2_kb_dy);
    else n_pass++;
    stun_frames = p2_stun_active ? 1 : 0;
    p1_atk_active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      frame();
      if (p2_stun_active) stun_frames++;
    end
    n_total++;
    if (stun_frames != 4) $display("FAIL block_stun_len: got %0d want 4", stun_frames);
    else n_pass++;
    p2_block = 1'b0; p1_atk_heavy = 1'b0;
  endtask

  task automatic test_trade();
    restart_round();
    p2_x = 10'd120; p2_face_right = 1'b0;
    p1_atk_active = 1'b1; p2_atk_active = 1'b1;
    frame();
    n_total++;
    if ({p1_hit_event, p2_hit_event} !== 2'b11)
      $display("FAIL trade_events: got %b want 11", {p1_hit_event, p2_hit_event});
    else n_pass++;
    n_total++;
    if (p1_hp !== 8'd95 || p2_hp !== 8'd95)
      $display("FAIL trade_hp: got %0d/%0d want 95/95", p1_hp, p2_hp);
    else n_pass++;
    n_total++;
    if (p1_kb_dx !== -8'sd2 || p2_kb_dx !== 8'sd2)
      $display("FAIL trade_kb: got %0d/%0d want -2/2", p1_kb_dx, p2_kb_dx);
    else n_pass++;
    p1_atk_active = 1'b0; p2_atk_active = 1'b0;
    frame();
  endtask

  task automatic test_ko();
    restart_round();
    p2_x = 10'd125; p1_atk_heavy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p1_atk_active = 1'b1; frame();
      p1_atk_active = 1'b0; frame();
    end
    n_total++;
    if (p2_hp !== 8'd4 || p2_ko !== 1'b0)
      $display("FAIL ko_eight: got hp %0d ko %b want 4 0", p2_hp, p2_ko);
    else n_pass++;
    p1_atk_active = 1'b1; frame();
    n_total++;
    if (p2_hp !== 8'd0) $display("FAIL ko_sat: got %0d want 0", p2_hp);
    else n_pass++;
    n_total++;
    if ({p2_ko, round_over, p2_hit_event, p1_ko} !== 4'b1110)
      $display("FAIL ko_flags: got %b want 1110", {p2_ko, round_over, p2_hit_event, p1_ko});
    else n_pass++;
    p1_atk_active = 1'b0; frame();
    p1_atk_active = 1'b1; frame();
    n_total++;
    if (p2_hit_event !== 1'b0 || p2_hp !== 8'd0)
      $display("FAIL ko_frozen: got hit %b hp %0d want 0 0", p2_hit_event, p2_hp);
    else n_pass++;
    restart_round();
    n_total++;
    if (p1_hp !== 8'd100 || p2_hp !== 8'd100)
      $display("FAIL restart_hp: got %0d/%0d want 100/100", p1_hp, p2_hp);
    else n_pass++;
    n_total++;
    if ({p1_ko, p2_ko, round_over, p2_hit_event, p2_stun_active, p2_kb_dx, p2_kb_dy} !== 21'b0)
      $display("FAIL restart_flags: got %h want 0",
               {p1_ko, p2_ko, round_over, p2_hit_event, p2_stun_active, p2_kb_dx, p2_kb_dy});
    else n_pass++;
    p1_atk_heavy = 1'b0;
  endtask

  task automatic test_edge();
    restart_round();
    p2_x = 10'd144; p1_atk_active = 1'b1;
    frame();
    n_total++;
    if (p2_hit_event !== 1'b0 || p2_hp !== 8'd100)
      $display("FAIL edge_touch: got hit %b hp %0d want 0 100", p2_hit_event, p2_hp);
    else n_pass++;
    p1_atk_active = 1'b0; frame();
    p2_x = 10'd143; p1_atk_active = 1'b1;
    frame();
    n_total++;
    if (p2_hit_event !== 1'b1 || p2_hp !== 8'd95)
      $display("FAIL edge_overlap: got hit %b hp %0d want 1 95", p2_hit_event, p2_hp);
    else n_pass++;
    p1_atk_active = 1'b0; frame();
  endtask

  task automatic test_async_reset();
    restart_round();
    p2_x = 10'd125; p1_atk_active = 1'b1;
    frame();
    p1_atk_active = 1'b0;
    n_total++;
    if (p2_stun_active !== 1'b1) $display("FAIL areset_pre_stun: got %b want 1", p2_stun_active);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (p2_hp !== 8'd100 || p2_stun_active !== 1'b0 || p2_hit_event !== 1'b0 ||
        p2_kb_dx !== 8'sd0 || p2_kb_dy !== 8'sd0)
      $display("FAIL areset: got hp %0d stun %b hit %b kb (%0d,%0d) want 100 0 0 (0,0)",
               p2_hp, p2_stun_active, p2_hit_event, p2_kb_dx, p2_kb_dy);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    restart_round();
    round_start = 1'b1; SCEN = 1'b1;
    model_step();
    @(posedge clk); #1;
    round_start = 1'b0; SCEN = 1'b0;
    for (int i = 0; i < 600; i++) begin
      p1_x = 10'(100 + $urandom_range(0, 50));
      p2_x = ($urandom_range(0, 9) == 0) ? p1_x : 10'(100 + $urandom_range(0, 50));
      p1_y = 10'(200 + $urandom_range(0, 16));
      p2_y = 10'(200 + $urandom_range(0, 16));
      p1_face_right = 1'($urandom_range(0, 1));
      p2_face_right = 1'($urandom_range(0, 1));
      p1_atk_active = ($urandom_range(0, 2) != 0);
      p2_atk_active = ($urandom_range(0, 2) != 0);
      p1_atk_heavy  = 1'($urandom_range(0, 1));
      p2_atk_heavy  = 1'($urandom_range(0, 1));
      p1_block      = ($urandom_range(0, 4) < 2);
      p2_block      = ($urandom_range(0, 4) < 2);
      SCEN          = ($urandom_range(0, 3) != 0);
      round_start   = ($urandom_range(0, 39) == 0);
      if (SCEN) model_step();
      @(posedge clk); #1;
      n_total++;
      if ({p1_hit_event, p1_block_event, p1_stun_active, p1_ko, int'(p1_hp)} !==
          {m_hit[0], m_blk[0], (m_stun[0] != 0), m_ko[0], m_hp[0]})
        $display("FAIL rnd_p1 cyc %0d: got %b%b%b%b hp %0d want %b%b%b%b hp %0d", i,
                 p1_hit_event, p1_block_event, p1_stun_active, p1_ko, p1_hp,
                 m_hit[0], m_blk[0], (m_stun[0] != 0), m_ko[0], m_hp[0]);
      else n_pass++;
      n_total++;
      if ({p2_hit_event, p2_block_event, p2_stun_active, p2_ko, int'(p2_hp)} !==
          {m_hit[1], m_blk[1], (m_stun[1] != 0), m_ko[1], m_hp[1]})
        $display("FAIL rnd_p2 cyc %0d: got %b%b%b%b hp %0d want %b%b%b%b hp %0d", i,
                 p2_hit_event, p2_block_event, p2_stun_active, p2_ko, p2_hp,
                 m_hit[1], m_blk[1], (m_stun[1] != 0), m_ko[1], m_hp[1]);
      else n_pass++;
      n_total++;
      if (int'(p1_kb_dx) != m_kbx[0] || int'(p1_kb_dy) != m_kby[0] ||
          int'(p2_kb_dx) != m_kbx[1] || int'(p2_kb_dy) != m_kby[1] ||
          round_over !== (m_ko[0] | m_ko[1]))
        $display("FAIL rnd_kb cyc %0d: got (%0d,%0d)(%0d,%0d) ro %b want (%0d,%0d)(%0d,%0d) ro %b", i,
                 p1_kb_dx, p1_kb_dy, p2_kb_dx, p2_kb_dy, round_over,
                 m_kbx[0], m_kby[0], m_kbx[1], m_kby[1], (m_ko[0] | m_ko[1]));
      else n_pass++;
    end
    SCEN = 1'b0; round_start = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; SCEN = 1'b0; round_start = 1'b0;
    p1_x = 10'd0; p1_y = 10'd0; p2_x = 10'd0; p2_y = 10'd0;
    p1_face_right = 1'b0; p1_atk_active = 1'b0; p1_atk_heavy = 1'b0; p1_block = 1'b0;
    p2_face_right = 1'b0; p2_atk_active = 1'b0; p2_atk_heavy = 1'b0; p2_block = 1'b0;
    test_reset();
    test_light_hit();
    test_block();
    test_trade();
    test_ko();
    test_edge();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/combat_resolver.md
# combat_resolver

Second-generation two-player hit resolver for the PvP fighter core. It sits between the per-player move state machines and the physics/HUD blocks, and is evaluated once per frame on `SCEN`. It adds several behaviours to the single-attack resolver:
- light and heavy attack classes, each with its own box, damage, stun and knockback;
- blocking with chip damage and blockstun;
- one connect per attack instance;
- HP tracking, KO detection and round restart.

## Interface
Parameters:
- `POS_WIDTH`, 10: position width (unsigned screen coordinates).
- `HP_MAX`, 100: HP at reset and at round start.
- `HP_W`, 8: HP register width.
- `HURT_W` / `HURT_H` / `HURT_OFFX` / `HURT_OFFY`, 16 / 28 / -8 / -28: hurtbox size and offset from (x, y).
- `L_W` / `L_H` / `L_FWD` / `L_UP`, 20 / 12 / 16 / -16: light hitbox.
- `H_W` / `H_H` / `H_FWD` / `H_UP`, 28 / 14 / 16 / -18: heavy hitbox.
- `L_DMG` / `H_DMG` / `CHIP_DMG`, 5 / 12 / 1: damage per light hit, heavy hit, and blocked hit.
- `L_STUN` / `H_STUN` / `BLK_STUN`, 8 / 16 / 4: stun lengths in frames.
- `L_KB_X` / `H_KB_X` / `KB_Y`, 2 / 6 / -2: knockback. A blocked hit gets `dx` = (class `KB_X`) >> 1 and `dy` = 0.

Ports (N = 1, 2):
- `clk`, in, 1: system clock. One clock; reset is asynchronous and active-high.
- `reset`, in, 1: asynchronous, active-high.
- `SCEN`, in, 1: frame enable. All state updates occur only on cycles where `SCEN` = 1.
- `round_start`, in, 1: restart the round. Sampled with `SCEN`.
- `pN_x`, `pN_y`, in, `POS_WIDTH`: anchor position.
- `pN_face_right`, in, 1: facing direction.
- `pN_atk_active`, in, 1: attack active frames.
- `pN_atk_heavy`, in, 1: attack class (1 = heavy). Valid while `pN_atk_active` = 1.
- `pN_block`, in, 1: holding guard.
- `pN_hit_event`, out, 1: one-frame pulse; player N took a clean hit.
- `pN_block_event`, out, 1: one-frame pulse; player N blocked a hit.
- `pN_stun_active`, out, 1: hitstun or blockstun in progress.
- `pN_kb_dx`, `pN_kb_dy`, out, signed 8: knockback applied to player N.
- `pN_hp`, out, `HP_W`: current HP.
- `pN_ko`, out, 1: HP has reached 0.
- `round_over`, out, 1: at least one KO has occurred this round.

## Operation
- **Geometry.** Positions are zero-extended, then all box arithmetic is signed at `POS_WIDTH`+2 bits.
  - Hurtbox: [x+`HURT_OFFX`, +`HURT_W`) by [y+`HURT_OFFY`, +`HURT_H`).
  - Hitbox x start is x+FWD when facing right, otherwise x−(FWD+W). Hitbox y start is y+UP.
  - Overlap uses strict inequalities, so boxes that only touch at an edge do not overlap.
- **Connect latch.** `pN_connected` is set when player N's attack lands, whether hit or blocked. It is cleared on any frame where `pN_atk_active` = 0.
  - An attack resolves only when it is active, not connected, overlapping, and `round_over` = 0.
- **Block condition.** The defender blocks when all of the following hold; otherwise the hit is clean:
  - `block` = 1;
  - the defender is not in stun;
  - the defender faces the attacker: `face_right` = (attacker x > defender x). If the x values are equal, the defender counts as facing the attacker.
- **Clean hit.** The defender:
  - pulses `hit_event`;
  - loses the class damage from HP;
  - has the stun counter loaded with the class stun value;
  - gets `kb_dx` = ±class `KB_X` (sign follows the attacker's facing) and `kb_dy` = `KB_Y`.
- **Blocked hit.** The defender:
  - pulses `block_event`;
  - loses `CHIP_DMG`;
  - has the stun counter loaded with `BLK_STUN`;
  - gets `kb_dx` = ±(`KB_X`>>1) and `kb_dy` = 0.
- **Combos.** A hit on an already-stunned defender reloads the stun counter.
- **Knockback hold.** `kb` outputs keep their last value until the next hit or block.
- **Stun.** `stun_active` = (counter != 0). The counter decrements once per `SCEN` frame and saturates at 0.
- **Damage.** HP subtraction saturates at 0.
  - A player's `ko` is set in the frame their HP becomes 0.
  - `round_over` = `p1_ko` | `p2_ko`.
- **Trades.** Both players' attacks resolve in the same frame, independently. A double KO sets both `ko` flags.
- **Round restart.** `round_start` with `SCEN` does the following, with priority over any hit in that frame:
  - HP = `HP_MAX`;
  - stun counters, KO flags, connect latches and event pulses cleared;
  - `kb` = 0.

## Timing
- Resolution has a latency of one `SCEN` frame. Overlap is combinational on the inputs; events, HP and stun update at the clock edge where `SCEN` = 1.
- Event pulses are high for exactly one `SCEN` frame. They clear on the next `SCEN` edge, and hold their value across cycles where `SCEN` = 0.
- Reset values: HP = `HP_MAX`; every other output and all internal state 0. Reset acts immediately, including mid-stun or mid-round.
- Stun of length S: `stun_active` is high for exactly S frames, starting in the frame of the event.

## Test plan
1. **Light hit.** p1 = (100, 200) facing right; p2 = (125, 200). p1 light attack active for 3 frames → one `p2_hit_event`; `p2_hp` 100→95; `p2_stun_active` high for 8 frames; `p2_kb` = (+2, −2); no second hit while the attack is held.
2. **Block.** Same positions; p2 `block` = 1, facing left; p1 heavy → `p2_block_event` with no `hit_event`; `p2_hp` = 99; stun 4 frames; `p2_kb` = (+3, 0).
3. **Trade.** p2 at x = 120 facing left; both players start light attacks in the same frame → both `hit_event` pulses in one frame; both HP = 95.
4. **KO.** Eight p1 heavies, attack released between each → `p2_hp` = 4. The ninth heavy → `p2_hp` = 0 (saturated), `p2_ko` = 1, `round_over` = 1. Further attacks produce no events. `round_start` → HP = 100 for both and all flags cleared.
5. **Edge.** p2_x = 144 → hurtbox edge touches the light hitbox → no hit. p2_x = 143 → hit.
6. **Async reset.** Assert `reset` mid-stun with `SCEN` = 0 → outputs zero (HP = 100) before the next clock edge.
